// File: rtl/w_mem_stream_loader.sv
// w_mem_stream_loader: write-side initiator for the weight memory wrapper.
// Takes a valid/ready stream of weight words and writes them to either the
// CNN or the FC write port at linear addresses starting from a base address.
// Optional running-XOR checksum is compiled in with W_MEM_LOADER_CHECKSUM_EN.
module w_mem_stream_loader #(
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 12,
    parameter int         CNT_W    = 13,
    parameter logic [2:0] MODE_CNN = 3'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_enable_cnn,
    output logic [ADDR_W-1:0] wr_addr_cnn,
    output logic [DATA_W-1:0] wr_data_cnn,
    output logic              wr_enable_fc,
    output logic [ADDR_W-1:0] wr_addr_fc,
    output logic [DATA_W-1:0] wr_data_fc,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_written
`ifdef W_MEM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum,
    output logic              checksum_ok,
    input  logic [DATA_W-1:0] expected_checksum
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  ww_q, ww_d;
    logic              cnn_en_q, cnn_en_d;
    logic [ADDR_W-1:0] cnn_addr_q, cnn_addr_d;
    logic [DATA_W-1:0] cnn_data_q, cnn_data_d;
    logic              fc_en_q, fc_en_d;
    logic [ADDR_W-1:0] fc_addr_q, fc_addr_d;
    logic [DATA_W-1:0] fc_data_q, fc_data_d;
    logic              hs_s;
    logic [ADDR_W-1:0] wr_addr_s;
`ifdef W_MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              csum_ok_q, csum_ok_d;
`endif

    assign hs_s      = (state_q == ST_LOAD) && in_valid;
    // Linear address; the FC subblock/row decode happens downstream.
    assign wr_addr_s = base_q + acc_q[ADDR_W-1:0];

    // Next-state, latching and write-register update logic.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        base_d     = base_q;
        num_d      = num_q;
        acc_d      = acc_q;
        ww_d       = ww_q;
        cnn_en_d   = 1'b0;
        cnn_addr_d = cnn_addr_q;
        cnn_data_d = cnn_data_q;
        fc_en_d    = 1'b0;
        fc_addr_d  = fc_addr_q;
        fc_data_d  = fc_data_q;
`ifdef W_MEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        csum_ok_d  = csum_ok_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    base_d     = base_addr;
                    num_d      = num_words;
                    acc_d      = {CNT_W{1'b0}};
                    ww_d       = {CNT_W{1'b0}};
                    // Both ports start clean so the unselected one stays at 0.
                    cnn_addr_d = {ADDR_W{1'b0}};
                    cnn_data_d = {DATA_W{1'b0}};
                    fc_addr_d  = {ADDR_W{1'b0}};
                    fc_data_d  = {DATA_W{1'b0}};
`ifdef W_MEM_LOADER_CHECKSUM_EN
                    csum_d     = {DATA_W{1'b0}};
                    csum_ok_d  = 1'b0;
`endif
                    state_d    = (num_words == {CNT_W{1'b0}}) ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    acc_d = acc_q + CNT_ONE;
                    ww_d  = ww_q + CNT_ONE;
                    if (mode_q == MODE_CNN) begin
                        cnn_en_d   = 1'b1;
                        cnn_addr_d = wr_addr_s;
                        cnn_data_d = in_data;
                    end else begin
                        fc_en_d   = 1'b1;
                        fc_addr_d = wr_addr_s;
                        fc_data_d = in_data;
                    end
`ifdef W_MEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                end else begin
                    acc_d = acc_q;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs_s && ((acc_q + CNT_ONE) == num_q)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
`ifdef W_MEM_LOADER_CHECKSUM_EN
                csum_ok_d = (csum_q == expected_checksum);
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 3'd0;
            base_q     <= {ADDR_W{1'b0}};
            num_q      <= {CNT_W{1'b0}};
            acc_q      <= {CNT_W{1'b0}};
            ww_q       <= {CNT_W{1'b0}};
            cnn_en_q   <= 1'b0;
            cnn_addr_q <= {ADDR_W{1'b0}};
            cnn_data_q <= {DATA_W{1'b0}};
            fc_en_q    <= 1'b0;
            fc_addr_q  <= {ADDR_W{1'b0}};
            fc_data_q  <= {DATA_W{1'b0}};
`ifdef W_MEM_LOADER_CHECKSUM_EN
            csum_q     <= {DATA_W{1'b0}};
            csum_ok_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            ww_q       <= ww_d;
            cnn_en_q   <= cnn_en_d;
            cnn_addr_q <= cnn_addr_d;
            cnn_data_q <= cnn_data_d;
            fc_en_q    <= fc_en_d;
            fc_addr_q  <= fc_addr_d;
            fc_data_q  <= fc_data_d;
`ifdef W_MEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            csum_ok_q  <= csum_ok_d;
`endif
        end
    end

    // Status outputs are pure decodes of the registered state.
    assign in_ready      = (state_q == ST_LOAD);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign words_written = ww_q;
    assign wr_enable_cnn = cnn_en_q;
    assign wr_addr_cnn   = cnn_addr_q;
    assign wr_data_cnn   = cnn_data_q;
    assign wr_enable_fc  = fc_en_q;
    assign wr_addr_fc    = fc_addr_q;
    assign wr_data_fc    = fc_data_q;
`ifdef W_MEM_LOADER_CHECKSUM_EN
    assign checksum      = csum_q;
    assign checksum_ok   = csum_ok_q;
`endif

endmodule
